// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, with valid/ready
// on both sides and optional signed/unsigned saturation on overflow.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one DIGIT slice per cycle, N = WIDTH/DIGIT cycles
// DONE  | result and flags held until out_ready
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
    logic [CW-1:0]    cnt_q;
    logic             cy_q, sub_q, sm_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, ovf_q, zero_q, neg_q;

    logic [DIGIT-1:0] da, db;
    logic [DIGIT:0]   dsum;
    logic             last, cmsb, cout, ovf_raw, accept;

    assign accept = in_valid && (state_q == IDLE);
    assign last   = (cnt_q == CW'(N - 1));

    // b_q already holds b or ~b, and cy_q starts as the +1 for subtraction
    always_comb begin
        da     = a_q[cnt_q*DIGIT +: DIGIT];
        db     = b_q[cnt_q*DIGIT +: DIGIT];
        dsum   = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, cy_q};
        cout   = dsum[DIGIT];
        acc_d  = acc_q;
        acc_d[cnt_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
        // only meaningful on the last digit, where slice bit DIGIT-1 is the word MSB
        cmsb    = dsum[DIGIT-1] ^ da[DIGIT-1] ^ db[DIGIT-1];
        ovf_raw = sm_q ? (cout ^ cmsb) : (sub_q ? ~cout : cout);
        result_d = acc_d;
        if ((SAT != 0) && ovf_raw) begin
            if (sm_q)
                result_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else
                result_d = sub_q ? '0 : '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            sub_q    <= 1'b0;
            sm_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            acc_q <= '0;
            cnt_q <= '0;
            cy_q  <= sub;
            sub_q <= sub;
            sm_q  <= signed_mode;
        end else if (state_q == CALC) begin
            acc_q <= acc_d;
            cy_q  <= cout;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                result_q <= result_d;
                carry_q  <= cout;
                ovf_q    <= ovf_raw;
                zero_q   <= (result_d == '0);
                neg_q    <= result_d[WIDTH-1];
            end
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign neg      = neg_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: five parameterisations driven from directed tables,
// hand-written handshake/reset sequences and random vectors against an arithmetic model.
module tb_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid_v[5], sub_v[5], sm_v[5], out_ready_v[5];
    logic [15:0] a_v[5], b_v[5];
    logic        in_ready_v[5], out_valid_v[5], carry_v[5], ov_v[5], zero_v[5], neg_v[5];
    logic [7:0]  r0, r1, r2, r3;
    logic [15:0] r4;

    int checks = 0;
    int errors = 0;

    int WV[5]   = '{8, 8, 8, 8, 16};
    int NV[5]   = '{4, 4, 8, 1, 4};
    int SATV[5] = '{0, 1, 0, 1, 0};

    addsub_serial #(.WIDTH(8), .DIGIT(2), .SAT(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .sub(sub_v[0]), .signed_mode(sm_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .result(r0),
        .carry(carry_v[0]), .overflow(ov_v[0]), .zero(zero_v[0]), .neg(neg_v[0]));
    addsub_serial #(.WIDTH(8), .DIGIT(2), .SAT(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .sub(sub_v[1]), .signed_mode(sm_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .result(r1),
        .carry(carry_v[1]), .overflow(ov_v[1]), .zero(zero_v[1]), .neg(neg_v[1]));
    addsub_serial #(.WIDTH(8), .DIGIT(1), .SAT(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2][7:0]), .b(b_v[2][7:0]), .sub(sub_v[2]), .signed_mode(sm_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .result(r2),
        .carry(carry_v[2]), .overflow(ov_v[2]), .zero(zero_v[2]), .neg(neg_v[2]));
    addsub_serial #(.WIDTH(8), .DIGIT(8), .SAT(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .a(a_v[3][7:0]), .b(b_v[3][7:0]), .sub(sub_v[3]), .signed_mode(sm_v[3]),
        .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]), .result(r3),
        .carry(carry_v[3]), .overflow(ov_v[3]), .zero(zero_v[3]), .neg(neg_v[3]));
    addsub_serial #(.WIDTH(16), .DIGIT(4), .SAT(0)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[4]), .in_ready(in_ready_v[4]),
        .a(a_v[4]), .b(b_v[4]), .sub(sub_v[4]), .signed_mode(sm_v[4]),
        .out_valid(out_valid_v[4]), .out_ready(out_ready_v[4]), .result(r4),
        .carry(carry_v[4]), .overflow(ov_v[4]), .zero(zero_v[4]), .neg(neg_v[4]));

    function automatic logic [15:0] res_of(int i);
        case (i)
            0:       return {8'h00, r0};
            1:       return {8'h00, r1};
            2:       return {8'h00, r2};
            3:       return {8'h00, r3};
            default: return r4;
        endcase
    endfunction

    // {out_valid, in_ready, result[15:0], carry, overflow, zero, neg}
    function automatic logic [21:0] outs(int i);
        return {out_valid_v[i], in_ready_v[i], res_of(i), carry_v[i], ov_v[i], zero_v[i], neg_v[i]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: returns {result[15:0], carry, overflow, zero, neg}
    function automatic logic [19:0] model(int i, longint a, longint b, bit s, bit m);
        longint w    = WV[i];
        longint full = longint'(1) << w;
        longint mask = full - 1;
        longint half = full >> 1;
        longint bb   = s ? ((~b) & mask) : b;
        longint sum  = a + bb + (s ? 1 : 0);
        longint res  = sum & mask;
        longint c    = sum >> w;
        longint sa   = (a >= half) ? a - full : a;
        longint sb   = (b >= half) ? b - full : b;
        longint sr   = s ? sa - sb : sa + sb;
        bit     ov;
        logic [15:0] r16;
        if (m) ov = (sr >= half) || (sr < -half);
        else   ov = s ? (a < b) : (a + b > mask);
        if (SATV[i] != 0 && ov) begin
            if (m) res = (sr > 0) ? half - 1 : half;
            else   res = s ? 0 : mask;
        end
        r16 = 16'(res);
        return {r16, c[0], ov, (res == 0), 1'((res >> (w - 1)) & 1)};
    endfunction

    // Starts and ends 1 time unit after a rising edge, with the instance in IDLE.
    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic m,
                          output logic [19:0] got, output int lat, output int rdy_bad);
        in_valid_v[i] = 1'b1;
        a_v[i] = a; b_v[i] = b; sub_v[i] = s; sm_v[i] = m;
        @(posedge clk); #1;
        in_valid_v[i] = 1'b0;
        a_v[i] = 16'($urandom); b_v[i] = 16'($urandom);
        sub_v[i] = 1'($urandom); sm_v[i] = 1'($urandom);
        lat = 0; rdy_bad = 0;
        while (out_valid_v[i] !== 1'b1 && lat < 40) begin
            if (in_ready_v[i] !== 1'b0) rdy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        got = {res_of(i), carry_v[i], ov_v[i], zero_v[i], neg_v[i]};
        out_ready_v[i] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[i] = 1'b0;
    endtask

    typedef struct {
        int          inst;
        logic [15:0] a, b;
        logic        s, m;
        logic [15:0] res;
        logic        c, ov, z, n;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] got, exp;
        logic [21:0] snap;
        int lat, rdy_bad, bad;

        tbl[0]  = '{0, 16'h03,   16'h01,   1'b1, 1'b0, 16'h02,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{0, 16'h81,   16'h81,   1'b1, 1'b0, 16'h00,   1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{0, 16'hF8,   16'h02,   1'b1, 1'b1, 16'hF6,   1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{0, 16'h7F,   16'hFF,   1'b1, 1'b1, 16'h80,   1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1, 16'h7F,   16'hFF,   1'b1, 1'b1, 16'h7F,   1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1, 16'h80,   16'hFF,   1'b0, 1'b1, 16'h80,   1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{0, 16'h02,   16'h05,   1'b1, 1'b0, 16'hFD,   1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1, 16'h02,   16'h05,   1'b1, 1'b0, 16'h00,   1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1, 16'hF0,   16'h20,   1'b0, 1'b0, 16'hFF,   1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{0, 16'hF0,   16'h20,   1'b0, 1'b0, 16'h10,   1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{4, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{3, 16'h7F,   16'h01,   1'b0, 1'b1, 16'h7F,   1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0;
            a_v[i] = '0; b_v[i] = '0; sub_v[i] = 1'b0; sm_v[i] = 1'b0;
        end
        #23;
        for (int i = 0; i < 5; i++) chk($sformatf("reset_state[%0d]", i), outs(i), 22'h100000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int k = 0; k < 12; k++) begin
            run_op(tbl[k].inst, tbl[k].a, tbl[k].b, tbl[k].s, tbl[k].m, got, lat, rdy_bad);
            chk($sformatf("vec%0d_result", k), got,
                {tbl[k].res, tbl[k].c, tbl[k].ov, tbl[k].z, tbl[k].n});
            chk($sformatf("vec%0d_latency", k), lat, NV[tbl[k].inst]);
            chk($sformatf("vec%0d_in_ready_calc", k), rdy_bad, 0);
        end

        // Backpressure: hold the result for 5 cycles, then release with in_valid already high
        in_valid_v[0] = 1'b1; a_v[0] = 16'h03; b_v[0] = 16'h01; sub_v[0] = 1'b1; sm_v[0] = 1'b0;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (out_valid_v[0] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", lat, 4);
        snap = outs(0);
        chk("bp_snapshot", snap, {2'b10, 16'h0002, 4'b1000});
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (outs(0) !== snap) bad++;
        end
        chk("bp_stable", bad, 0);
        in_valid_v[0] = 1'b1; a_v[0] = 16'h11; out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        chk("bp_release", {out_valid_v[0], in_ready_v[0]}, 2'b01);
        in_valid_v[0] = 1'b0;

        // Asynchronous reset in the middle of CALC
        in_valid_v[0] = 1'b1; a_v[0] = 16'h05; b_v[0] = 16'h03; sub_v[0] = 1'b0; sm_v[0] = 1'b0;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_calc", outs(0), 22'h100000);
        #2;
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid_v[0] !== 1'b0) bad++;
        end
        chk("rst_no_out_valid", bad, 0);
        run_op(0, 16'h05, 16'h03, 1'b0, 1'b0, got, lat, rdy_bad);
        chk("rst_next_op", got, model(0, 5, 3, 1'b0, 1'b0));
        chk("rst_next_latency", lat, 4);

        // Random sweep across all parameterisations
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 40; k++) begin
                logic [15:0] ra, rb;
                logic rs, rm;
                ra = (WV[i] == 16) ? 16'($urandom) : {8'h00, 8'($urandom)};
                rb = (WV[i] == 16) ? 16'($urandom) : {8'h00, 8'($urandom)};
                rs = 1'($urandom);
                rm = 1'($urandom);
                run_op(i, ra, rb, rs, rm, got, lat, rdy_bad);
                exp = model(i, longint'(ra), longint'(rb), rs, rm);
                chk($sformatf("rand_u%0d_a%0h_b%0h_s%0b_m%0b", i, ra, rb, rs, rm), got, exp);
                chk($sformatf("rand_u%0d_latency", i), lat, NV[i]);
                chk($sformatf("rand_u%0d_in_ready_calc", i), rdy_bad, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
